// File: rtl/serial_rx_pkg.sv
// serial_pkg: definitions shared by the serial receiver and transmitter.
//   CLKS_9600  - sysclk cycles per bit at 9600 baud from a 50 MHz clock.
//   TIMER_W    - width of the bit-period timer.
//   rx_state_t - receiver FSM state encoding.
//   maj3()     - 2-of-3 majority vote.
package serial_pkg;

  localparam int CLKS_9600 = 5208;
  localparam int TIMER_W   = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for asynchronous inputs
// (buttons, serial lines).
//   clk  in  1 - destination clock
//   srst in  1 - synchronous active-high reset; both flops load RESET_VAL
//   d    in  1 - asynchronous input
//   q    out 1 - synchronised output, two cycles after d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8N1 asynchronous serial receiver with a one-entry holding buffer.
//   sysclk    in  1 - clock, rising edge
//   reset     in  1 - synchronous active-high reset
//   serial_in in  1 - asynchronous serial line, idle high
//   rx_ready  in  1 - consumer takes rx_data when rx_valid && rx_ready
//   rx_data   out 8 - received byte, stable while rx_valid
//   rx_valid  out 1 - holding buffer full
//   frame_err out 1 - one-cycle pulse when the stop bit samples low
//   overrun   out 1 - sticky, set when a completed byte is dropped
//   busy      out 1 - FSM not in IDLE
// Build option: define SERIAL_RX_MAJORITY_EN to decide each bit by a 2-of-3
// vote of samples at HALF-2, HALF-1, HALF (all sample points one cycle later).
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_9600
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  // Data and stop bits are timed from the start-bit decision, so their
  // decision point is a whole bit later and already carries the start offset.
  localparam logic [TIMER_W-1:0] BIT_END = TIMER_W'(CLKS_PER_BIT - 1);
`ifdef SERIAL_RX_MAJORITY_EN
  localparam logic [TIMER_W-1:0] START_DEC = TIMER_W'(HALF);
`else
  localparam logic [TIMER_W-1:0] START_DEC = TIMER_W'(HALF - 1);
`endif

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (sysclk),
    .srst (reset),
    .d    (serial_in),
    .q    (rx_s)
  );

  rx_state_t           state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                deliver_q, deliver_d;     // good stop seen last cycle
  logic                ferr_pend_q, ferr_pend_d; // bad stop seen last cycle
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
`ifdef SERIAL_RX_MAJORITY_EN
  logic [1:0]          maj_q, maj_d;
`endif

  logic [TIMER_W-1:0]  dec_pt;
  logic                at_dec;
  logic                bit_val;
  logic                drain;

  always_comb begin
    dec_pt = (state_q == ST_START) ? START_DEC : BIT_END;
    at_dec = (timer_q == dec_pt);
`ifdef SERIAL_RX_MAJORITY_EN
    maj_d = maj_q;
    if (timer_q == dec_pt - TIMER_W'(2)) maj_d[0] = rx_s;
    if (timer_q == dec_pt - TIMER_W'(1)) maj_d[1] = rx_s;
    bit_val = maj3(maj_q[0], maj_q[1], rx_s);
`else
    bit_val = rx_s;
`endif

    state_d     = state_q;
    timer_d     = timer_q + TIMER_W'(1);
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    deliver_d   = 1'b0;
    ferr_pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (at_dec) begin
          timer_d = '0;
          if (bit_val) begin
            state_d = ST_IDLE;          // false start: glitch, not a frame
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (at_dec) begin
          timer_d   = '0;
          shreg_d   = {bit_val, shreg_q[7:1]};  // LSB first: first bit ends at bit 0
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_dec) begin
          timer_d = '0;
          if (bit_val) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;        // mid-stop: half a bit to catch next start
          end else begin
            ferr_pend_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        timer_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Holding buffer: a drain in the same cycle frees the slot for a new byte.
    drain       = rx_valid_q && rx_ready;
    rx_valid_d  = rx_valid_q && !drain;
    rx_data_d   = rx_data_q;
    overrun_d   = overrun_q;
    if (deliver_q) begin
      if (!rx_valid_q || drain) begin
        rx_valid_d = 1'b1;
        rx_data_d  = shreg_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
    frame_err_d = ferr_pend_q;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      deliver_q   <= 1'b0;
      ferr_pend_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_RX_MAJORITY_EN
      maj_q       <= 2'b11;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      deliver_q   <= deliver_d;
      ferr_pend_q <= ferr_pend_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef SERIAL_RX_MAJORITY_EN
      maj_q       <= maj_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: doc/serial_rx.md
# serial_rx

Asynchronous 8N1 serial receiver that turns the raw `serial_in` line into bytes for the tweet storage and control logic. Synchronises the line, validates the start bit, samples 8 data bits LSB-first at mid-bit, checks the stop bit, and presents each byte through a one-entry holding buffer with a valid/ready handshake. Sits between the board's serial input pin and the tweet store, replacing ad-hoc bit counting in the consumer.

## Interface
- `CLKS_PER_BIT`, default 5208: sysclk cycles per serial bit (50 MHz / 9600 baud).
- `sysclk  in  1`: single clock; all logic on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `serial_in  in  1`: asynchronous serial line, idle high.
- `rx_ready  in  1`: consumer accepts `rx_data` on a cycle where `rx_valid && rx_ready`.
- `rx_data  out  8`: received byte, stable while `rx_valid` is high.
- `rx_valid  out  1`: holding buffer full.
- `frame_err  out  1`: one-cycle pulse when the stop bit samples low.
- `overrun  out  1`: sticky; set when a completed byte is dropped; cleared only by reset.
- `busy  out  1`: high in any state other than IDLE.

## Operation
- Input path: 2-flop synchroniser, giving `rx_s`. All decisions use `rx_s` only.
- `HALF = CLKS_PER_BIT/2` (integer division). Bit timer is a 13-bit up-counter; it is reset on every state entry and on every bit boundary.
- States:
  - IDLE: `rx_s == 0` → START, timer cleared.
  - START: when timer reaches HALF-1, sample `rx_s`. If 1 (false start), go to IDLE. If 0, go to DATA with bit index 0 and timer cleared.
  - DATA: every CLKS_PER_BIT cycles, shift the sample into `shreg[7]` with a right shift, so the first bit lands at bit 0. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - If 1, deliver the byte and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. This covers a line held low of any length.
- Delivery, in the cycle after the stop sample:
  - Buffer empty, or being drained in that same cycle: load `rx_data`, assert `rx_valid`.
  - Buffer full and not being drained that cycle: keep the old byte, set `overrun`.
- Handshake: `rx_valid` drops the cycle after `rx_valid && rx_ready`, unless a new byte loads in that same cycle.
- Reset values: `rx_valid=0`, `rx_data=8'h00`, `frame_err=0`, `overrun=0`, `busy=0`. State = IDLE. Synchroniser flops preset to 1.
- Reset mid-frame aborts the frame without delivering a byte. If the line is still low after reset, a new start is detected and rejected or accepted by the normal START check.

## Timing
- Let t0 be the first sysclk edge at which `serial_in` is registered low.
  - START is entered at t0+2.
  - Start sample at t0+2+HALF.
  - Data bit n sampled at t0+2+HALF+(n+1)·CLKS_PER_BIT.
  - Stop sample at t0+2+HALF+9·CLKS_PER_BIT.
  - `rx_valid`/`frame_err` registered one cycle after the stop sample.
- Back-to-back frames are accepted: IDLE is re-entered at mid-stop-bit, so the next start edge is detected with half a bit of margin.
- Throughput is one byte per 10·CLKS_PER_BIT cycles. The consumer has roughly one frame time to drain the buffer before an overrun.

## Configuration
- `SERIAL_RX_MAJORITY_EN` defined:
  - Each bit (start, data, stop) takes three `rx_s` samples, at timer values HALF-2, HALF-1 and HALF.
  - The bit value is the 2-of-3 majority, decided at HALF.
  - Every sample point in Timing moves 1 cycle later.
- Undefined: single sample at HALF-1, exactly as in Operation.

## Structure
- Shared package `serial_pkg` holds:
  - the state encoding (IDLE, START, DATA, STOP, BREAK) as localparams or a typedef;
  - the constant `CLKS_9600 = 5208`, which the transmitter-side divider also uses.
- One sub-module, `sync_2ff`: 1-bit two-flop synchroniser with a reset-to-1 parameter, reused for button and line inputs.

## Test plan
- Frame for 0x41 (start 0, bits 1000 0010 LSB-first, stop 1) at CLKS_PER_BIT=16 → `rx_data=8'h41`, `rx_valid=1` at t0+2+8+144+1; `frame_err=0`.
- `serial_in` low for 4 cycles, then high → no `rx_valid`, `busy` returns to 0 at the start sample.
- Frame for 0x55 with stop bit 0 → `frame_err` pulses once, `rx_valid` stays 0, FSM in BREAK until line high, then next frame 0x08 received correctly.
- `rx_ready=0`, send 0x31 then 0x32 → `rx_data=8'h31`, `overrun=1`. Then `rx_ready=1` → `rx_valid` falls the next cycle, `overrun` stays 1 until reset.
- Assert `reset` one cycle during bit 4 of a frame → all outputs at reset values next cycle, no byte delivered. A following clean 0x7A frame is received.
- With `SERIAL_RX_MAJORITY_EN`, 0x00 frame with a 1-cycle high glitch at timer HALF-1 of bit 3 → `rx_data=8'h00`. Without the macro, the same stimulus → `8'h08`.
